// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter for the register-file write port: ld > alu > lnk with aging promotion.
// Optional forwarding compare on the registered write is compiled in with `define WB_FWD_EN.
module regs_wb_arbiter #(
   parameter int unsigned AGE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_wreg,
   input  logic [31:0] alu_wdata,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_wreg,
   input  logic [31:0] ld_wdata,
   input  logic        lnk_valid,
   output logic        lnk_ready,
   input  logic [31:0] lnk_inst_address,
   output logic        RegWrite,
   output logic [4:0]  wreg,
   output logic [31:0] wdata,
   output logic        wb_stall,
`ifdef WB_FWD_EN
   input  logic [4:0]  rreg_a,
   input  logic [4:0]  rreg_b,
   output logic        fwd_a_hit,
   output logic        fwd_b_hit,
   output logic [31:0] fwd_a_data,
   output logic [31:0] fwd_b_data,
`endif
   output logic [15:0] stall_cnt
);

   localparam logic [3:0] AGE_SAT = 4'(AGE_MAX);

   logic [3:0]  r_age_ld, r_age_alu, r_age_lnk;
   logic        r_regwrite;
   logic [4:0]  r_wreg;
   logic [31:0] r_wdata;
   logic [15:0] r_stall_cnt;
   logic        w_pro_ld, w_pro_alu, w_pro_lnk;
   logic        w_gnt_ld, w_gnt_alu, w_gnt_lnk;

   function automatic logic [3:0] age_next(input logic valid, input logic gnt,
                                           input logic [3:0] age);
      if (valid && !gnt)
         return (age == AGE_SAT) ? age : age + 4'd1;
      return 4'd0;
   endfunction

   assign w_pro_ld  = ld_valid  && (r_age_ld  == AGE_SAT);
   assign w_pro_alu = alu_valid && (r_age_alu == AGE_SAT);
   assign w_pro_lnk = lnk_valid && (r_age_lnk == AGE_SAT);

   // Promoted requesters first (in base order), then plain base order ld > alu > lnk.
   always_comb begin
      w_gnt_ld  = 1'b0;
      w_gnt_alu = 1'b0;
      w_gnt_lnk = 1'b0;
      if (!rst) begin
         w_gnt_ld = 1'b0;
      end else if (w_pro_ld) begin
         w_gnt_ld = 1'b1;
      end else if (w_pro_alu) begin
         w_gnt_alu = 1'b1;
      end else if (w_pro_lnk) begin
         w_gnt_lnk = 1'b1;
      end else if (ld_valid) begin
         w_gnt_ld = 1'b1;
      end else if (alu_valid) begin
         w_gnt_alu = 1'b1;
      end else if (lnk_valid) begin
         w_gnt_lnk = 1'b1;
      end
   end

   assign ld_ready  = w_gnt_ld;
   assign alu_ready = w_gnt_alu;
   assign lnk_ready = w_gnt_lnk;
   assign wb_stall  = (ld_valid && !w_gnt_ld) || (alu_valid && !w_gnt_alu) ||
                      (lnk_valid && !w_gnt_lnk);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_age_ld    <= 4'd0;
         r_age_alu   <= 4'd0;
         r_age_lnk   <= 4'd0;
         r_stall_cnt <= 16'd0;
      end else begin
         r_age_ld  <= age_next(ld_valid,  w_gnt_ld,  r_age_ld);
         r_age_alu <= age_next(alu_valid, w_gnt_alu, r_age_alu);
         r_age_lnk <= age_next(lnk_valid, w_gnt_lnk, r_age_lnk);
         if (wb_stall && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   // Writes to r0 are accepted but never reach the port; wreg/wdata keep their last value.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_regwrite <= 1'b0;
         r_wreg     <= 5'd0;
         r_wdata    <= 32'd0;
      end else begin
         r_regwrite <= 1'b0;
         if (w_gnt_ld && (ld_wreg != 5'd0)) begin
            r_regwrite <= 1'b1;
            r_wreg     <= ld_wreg;
            r_wdata    <= ld_wdata;
         end else if (w_gnt_alu && (alu_wreg != 5'd0)) begin
            r_regwrite <= 1'b1;
            r_wreg     <= alu_wreg;
            r_wdata    <= alu_wdata;
         end else if (w_gnt_lnk) begin
            r_regwrite <= 1'b1;
            r_wreg     <= 5'd31;
            r_wdata    <= lnk_inst_address + 32'd8;
         end
      end
   end

   assign RegWrite  = r_regwrite;
   assign wreg      = r_wreg;
   assign wdata     = r_wdata;
   assign stall_cnt = r_stall_cnt;

`ifdef WB_FWD_EN
   assign fwd_a_hit  = r_regwrite && (r_wreg == rreg_a) && (rreg_a != 5'd0);
   assign fwd_b_hit  = r_regwrite && (r_wreg == rreg_b) && (rreg_b != 5'd0);
   assign fwd_a_data = r_wdata;
   assign fwd_b_data = r_wdata;
`endif

endmodule
